// File: rtl/mic1_run_ctrl_pkg.sv
// Shared types and default constants for the MIC-1 run-control unit.
package mic1_run_ctrl_pkg;

  // Run-control states; the encoding is fixed at 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_CLEAR = 3'd4
  } run_state_e;

  // Default parameter values for the board build.
  localparam int DEF_DB_CYCLES = 100000;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_STEP_LEN  = 1;
  localparam int DEF_LED_W     = 4;

  // The MIC-1 datapath is clocked only while running or stepping.
  function automatic logic state_enables_core(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/mic1_run_ctrl_debounce.sv
// Button conditioner: two-flop synchroniser, stable-level debounce and a
// registered one-cycle pulse on the debounced rising edge. Release edges are
// debounced like presses but never produce a pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_dly_q, stable_dly_d;
  logic          pulse_q, pulse_d;

  // Next-state logic: the stable level only follows the synchronised input
  // after DB_CYCLES consecutive samples that disagree with it; any sample
  // that agrees restarts the count, which is what swallows bounce.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    pulse_d      = stable_q & ~stable_dly_q;
    if (sync2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // All debounce state clears to 0 so reset release cannot fake a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= CNT_ZERO;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/mic1_run_ctrl.sv
// Run-control unit for the MIC-1 board: turns debounced button presses into
// a clock enable and a synchronous clear for the core, counts enabled cycles
// and stops on a cycle-count breakpoint.
// Handshake: none; button pulses are single-cycle strobes and every output
// is a registered Moore output that changes one cycle after its cause.
module mic1_run_ctrl
  import mic1_run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STEP_LEN  = DEF_STEP_LEN,
  parameter int LED_W     = DEF_LED_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_stop,
  input  logic             btn_step,
  input  logic             btn_clear,
  input  logic             bp_en,
  input  logic [CNT_W-1:0] bp_value,
  output logic             mic1_en,
  output logic             mic1_clear,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             led_run,
  output logic             led_idle,
  output logic             led_break,
  output logic [LED_W-1:0] led_step
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_LEN);

  logic run_p, stop_p, step_p, clear_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk(clk), .rst(reset), .btn_raw(btn_run), .pulse(run_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .rst(reset), .btn_raw(btn_stop), .pulse(stop_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk(clk), .rst(reset), .btn_raw(btn_step), .pulse(step_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk(clk), .rst(reset), .btn_raw(btn_clear), .pulse(clear_p)
  );

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic             lrun_q, lrun_d;
  logic             lidle_q, lidle_d;
  logic             lbrk_q, lbrk_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             bp_hit;

  // Next state, counters and output decode. Pulse priority is
  // clear > stop > run > step; a breakpoint loses to stop but the enabled
  // cycle that coincides with it still counts.
  always_comb begin
    cnt_inc = cnt_q + CNT_ONE;
    bp_hit  = bp_en & en_q & (cnt_inc == bp_value);
    state_d = state_q;
    cnt_d   = en_q ? cnt_inc : cnt_q;
    left_d  = left_q;
    if (clear_p) begin
      state_d = ST_CLEAR;
      cnt_d   = CNT_ZERO;
      left_d  = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE, ST_BREAK: begin
          if (stop_p) begin
            state_d = ST_IDLE;
          end else if (run_p) begin
            state_d = ST_RUN;
          end else if (step_p) begin
            state_d = ST_STEP;
            left_d  = STEP_LOAD;
          end
        end
        ST_RUN: begin
          if (stop_p) begin
            state_d = ST_IDLE;
          end else if (bp_hit) begin
            state_d = ST_BREAK;
          end
        end
        ST_STEP: begin
          // Extra step presses are ignored until the burst ends.
          if (stop_p) begin
            state_d = ST_IDLE;
            left_d  = CNT_ZERO;
          end else if (bp_hit) begin
            state_d = ST_BREAK;
            left_d  = CNT_ZERO;
          end else if (left_q == CNT_ONE) begin
            state_d = ST_IDLE;
            left_d  = CNT_ZERO;
          end else begin
            left_d = left_q - CNT_ONE;
          end
        end
        ST_CLEAR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          left_d  = CNT_ZERO;
        end
      endcase
    end
    en_d    = state_enables_core(state_d);
    clr_d   = (state_d == ST_CLEAR);
    lrun_d  = state_enables_core(state_d);
    lidle_d = (state_d == ST_IDLE);
    lbrk_d  = (state_d == ST_BREAK);
  end

  // Single state register; outputs are registered from the next-state
  // decode so reset drops the core enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      left_q  <= CNT_ZERO;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      lrun_q  <= 1'b0;
      lidle_q <= 1'b1;
      lbrk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      lrun_q  <= lrun_d;
      lidle_q <= lidle_d;
      lbrk_q  <= lbrk_d;
    end
  end

  assign mic1_en    = en_q;
  assign mic1_clear = clr_q;
  assign cycle_cnt  = cnt_q;
  assign led_run    = lrun_q;
  assign led_idle   = lidle_q;
  assign led_break  = lbrk_q;
  assign led_step   = cnt_q[LED_W-1:0];

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Bench for mic1_run_ctrl: directed scenarios with hand-computed timing,
// then randomized button activity, all checked against a behavioural model.
module tb_mic1_run_ctrl;

  localparam int DB = 4;
  localparam int CW = 8;
  localparam int SL = 3;
  localparam int LW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3, M_CLEAR = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]    btn;  // 0 run, 1 stop, 2 step, 3 clear
  logic          bp_en;
  logic [CW-1:0] bp_value;
  logic          mic1_en, mic1_clear, led_run, led_idle, led_break;
  logic [CW-1:0] cycle_cnt;
  logic [LW-1:0] led_step;

  mic1_run_ctrl #(.DB_CYCLES(DB), .CNT_W(CW), .STEP_LEN(SL), .LED_W(LW)) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn[0]), .btn_stop(btn[1]), .btn_step(btn[2]), .btn_clear(btn[3]),
    .bp_en(bp_en), .bp_value(bp_value),
    .mic1_en(mic1_en), .mic1_clear(mic1_clear), .cycle_cnt(cycle_cnt),
    .led_run(led_run), .led_idle(led_idle), .led_break(led_break),
    .led_step(led_step)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level of a button flips once the DB samples taken two to
  // DB+1 edges ago all disagree with it; a press is seen by the control
  // logic two edges after the level rises.
  int m_state;
  int m_cnt;
  int m_left;
  bit m_lvl[4];
  bit m_lvl_d[4];
  bit m_pulse[4];
  bit hist[4][$];

  function automatic logic [4:0] exp_ctrl(input int s);
    return {(s == M_RUN || s == M_STEP), (s == M_CLEAR), (s == M_RUN || s == M_STEP),
            (s == M_IDLE), (s == M_BREAK)};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      m_left  = 0;
      for (int b = 0; b < 4; b++) begin
        m_lvl[b] = 0; m_lvl_d[b] = 0; m_pulse[b] = 0;
        hist[b].delete();
      end
    end else begin
      bit en, hit, flip, smp, np;
      int ns;
      en  = (m_state == M_RUN || m_state == M_STEP);
      hit = bp_en && en && (((m_cnt + 1) % (1 << CW)) == int'(bp_value));
      ns  = m_state;
      if (m_pulse[3]) begin
        ns = M_CLEAR; m_cnt = 0; m_left = 0;
      end else begin
        if (en) m_cnt = (m_cnt + 1) % (1 << CW);
        case (m_state)
          M_IDLE, M_BREAK: begin
            if (m_pulse[1]) ns = M_IDLE;
            else if (m_pulse[0]) ns = M_RUN;
            else if (m_pulse[2]) begin ns = M_STEP; m_left = SL; end
          end
          M_RUN: begin
            if (m_pulse[1]) ns = M_IDLE;
            else if (hit) ns = M_BREAK;
          end
          M_STEP: begin
            if (m_pulse[1]) ns = M_IDLE;
            else if (hit) ns = M_BREAK;
            else if (m_left == 1) ns = M_IDLE;
            else m_left = m_left - 1;
          end
          default: ns = M_IDLE;
        endcase
      end
      m_state = ns;
      for (int b = 0; b < 4; b++) begin
        hist[b].push_front(btn[b]);
        if (hist[b].size() > DB + 2) void'(hist[b].pop_back());
        np   = m_lvl[b] & ~m_lvl_d[b];
        flip = 1;
        for (int j = 2; j <= DB + 1; j++) begin
          smp = (j < hist[b].size()) ? hist[b][j] : 1'b0;
          if (smp == m_lvl[b]) flip = 0;
        end
        m_lvl_d[b] = m_lvl[b];
        if (flip) m_lvl[b] = ~m_lvl[b];
        m_pulse[b] = np;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("ctrl", {27'd0, mic1_en, mic1_clear, led_run, led_idle, led_break},
            {27'd0, exp_ctrl(m_state)});
      check("cycle_cnt", {24'd0, cycle_cnt}, m_cnt);
      check("led_step", {28'd0, led_step}, m_cnt % (1 << LW));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- driver ----------------
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n_en;
    reset = 1'b1; btn = '0; bp_en = 1'b0; bp_value = '0;
    ticks(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_en", mic1_en, 0);
    check("rst_idle", led_idle, 1);
    check("rst_cnt", cycle_cnt, 0);

    // Run press held 20 cycles, then stop press.
    for (int k = 0; k < 50; k++) begin
      if (k == 7)  check("run_lat_early", mic1_en, 0);
      if (k == 8)  begin check("run_lat", mic1_en, 1); check("run_cnt0", cycle_cnt, 0); end
      if (k == 11) begin check("run_cnt3", cycle_cnt, 3); check("run_led", led_run, 1); end
      if (k == 37) begin check("stop_pre_en", mic1_en, 1); check("stop_pre_cnt", cycle_cnt, 29); end
      if (k == 38) begin check("stop_en", mic1_en, 0); check("stop_cnt", cycle_cnt, 30); end
      if (k == 45) check("stop_frozen", cycle_cnt, 30);
      btn[0] = (k < 20);
      btn[1] = (k >= 30 && k < 40);
      @(negedge clk);
    end

    // Step press held 50 cycles: exactly one burst.
    n_en = 0;
    btn[2] = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (k == 50) btn[2] = 1'b0;
      @(negedge clk);
      n_en += int'(mic1_en);
    end
    check("step_burst_len", n_en, SL);
    check("step_cnt", cycle_cnt, 33);
    check("step_idle", led_idle, 1);

    // Clear while running with cycle_cnt at 37.
    for (int k = 0; k < 30; k++) begin
      if (k == 12) begin check("clr_pre_cnt", cycle_cnt, 37); check("clr_pre_en", mic1_en, 1); end
      if (k == 13) begin
        check("clr_pulse", mic1_clear, 1); check("clr_cnt", cycle_cnt, 0); check("clr_en", mic1_en, 0);
      end
      if (k == 14) begin check("clr_done", mic1_clear, 0); check("clr_idle", led_idle, 1); end
      btn[0] = (k < 10);
      btn[3] = (k >= 5 && k < 15);
      @(negedge clk);
    end

    // Breakpoint at 10, then resume past it.
    bp_en = 1'b1; bp_value = 8'd10;
    for (int k = 0; k < 45; k++) begin
      if (k == 17) begin check("bp_pre_en", mic1_en, 1); check("bp_pre_cnt", cycle_cnt, 9); end
      if (k == 18) begin
        check("bp_en_low", mic1_en, 0); check("bp_cnt", cycle_cnt, 10); check("bp_led", led_break, 1);
      end
      if (k == 33) begin check("bp_resume_en", mic1_en, 1); check("bp_resume_cnt", cycle_cnt, 10); end
      if (k == 35) check("bp_past", cycle_cnt, 12);
      btn[0] = (k < 10) || (k >= 25 && k < 35);
      @(negedge clk);
    end
    btn[1] = 1'b1; ticks(12); btn[1] = 1'b0; ticks(10);
    bp_en = 1'b0;

    // Bouncing run button: 3-cycle glitches must not produce a press.
    n_en = 0;
    for (int g = 0; g < 5; g++) begin
      btn[0] = 1'b1; ticks(3); n_en += int'(mic1_en);
      btn[0] = 1'b0; ticks(3); n_en += int'(mic1_en);
    end
    ticks(10);
    check("glitch_no_run", n_en + int'(mic1_en), 0);
    check("glitch_idle", led_idle, 1);
    btn[0] = 1'b1;
    ticks(8);
    check("stable_press_run", led_run, 1);
    ticks(4); btn[0] = 1'b0; ticks(8);
    btn[1] = 1'b1; ticks(10); btn[1] = 1'b0; ticks(10);
    check("stable_press_stopped", led_idle, 1);

    // Reset in the middle of a step burst.
    btn[2] = 1'b1;
    for (int i = 0; i < 20 && !mic1_en; i++) @(negedge clk);
    check("step_started", mic1_en, 1);
    #2 reset = 1'b1; btn = '0;
    #1;
    check("arst_en", mic1_en, 0);
    check("arst_clear", mic1_clear, 0);
    check("arst_leds", {led_run, led_idle, led_break}, 3'b010);
    check("arst_cnt", cycle_cnt, 0);
    check("arst_led_step", led_step, 0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    n_en = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_en += int'(mic1_en) + int'(!led_idle);
    end
    check("post_rst_quiet", n_en, 0);

    // Randomized button activity.
    for (int it = 0; it < 320; it++) begin
      int r;
      if ($urandom_range(0, 7) == 0) begin
        bp_en    = 1'($urandom_range(0, 1));
        bp_value = CW'((m_cnt + $urandom_range(1, 40)) % (1 << CW));
      end
      r = $urandom_range(0, 19);
      if (r < 7)       btn = 4'b0001;
      else if (r < 11) btn = 4'b0010;
      else if (r < 16) btn = 4'b0100;
      else if (r < 17) btn = 4'b1000;
      else             btn = 4'($urandom_range(0, 15));
      ticks($urandom_range(1, 12));
      btn = '0;
      ticks($urandom_range(1, 12));
    end
    ticks(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mic1_run_ctrl.md
# mic1_run_ctrl

Parametrised run-control unit for the MIC-1 board front-end: debounces four push-buttons and turns them into a clock-enable for the MIC-1 datapath. Supports free run, a multi-cycle step burst, stop, a synchronous soft clear, and a cycle-counter breakpoint. Sits between the board buttons/LEDs and the MIC-1 core's enable/clear inputs.

## Interface
Parameters:
- DB_CYCLES, 100000, consecutive stable cycles required before a debounced level changes (≥1)
- CNT_W, 16, width of the executed-cycle counter and breakpoint value
- STEP_LEN, 1, enabled MIC-1 cycles per step press (1..2^CNT_W-1)
- LED_W, 4, width of the step LED bus (≤ CNT_W)

Ports:
- clk  in  1  system clock; one clock domain, all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- btn_run  in  1  raw button, active-high, asynchronous to clk
- btn_stop  in  1  raw button
- btn_step  in  1  raw button
- btn_clear  in  1  raw button, soft clear
- bp_en  in  1  breakpoint enable, quasi-static
- bp_value  in  CNT_W  breakpoint cycle count
- mic1_en  out  1  MIC-1 clock enable
- mic1_clear  out  1  one-cycle synchronous clear pulse to MIC-1
- cycle_cnt  out  CNT_W  executed (enabled) cycle count
- led_run, led_idle, led_break  out  1 each  state indicators
- led_step  out  LED_W  cycle_cnt[LED_W-1:0]

## Operation
- Each button passes through btn_debounce, which produces a one-cycle rise pulse (run_p, stop_p, step_p, clear_p). Holding a button yields exactly one pulse. Release edges are ignored.
- Pulse priority within a cycle: clear > stop > run > step.
- States:
  - IDLE: mic1_en=0, led_idle=1.
  - RUN: mic1_en=1, led_run=1.
  - STEP: mic1_en=1, led_run=1, step_left counter active.
  - BREAK: mic1_en=0, led_break=1.
  - CLEAR: mic1_en=0, mic1_clear=1.
- All state outputs are Moore, registered.
- cycle_cnt increments in every cycle where mic1_en=1. It wraps from 2^CNT_W-1 to 0.
- Transitions:
  - Any state, clear_p → CLEAR.
  - IDLE: run_p → RUN. step_p → STEP, with step_left loaded to STEP_LEN.
  - RUN: stop_p → IDLE. Breakpoint hit → BREAK.
  - STEP: stop_p → IDLE (burst aborted). Breakpoint hit → BREAK. step_left==1 → IDLE. Otherwise step_left decrements. Further step_p during STEP is ignored.
  - BREAK: run_p → RUN. step_p → STEP (reload). stop_p → IDLE.
  - CLEAR: lasts one cycle, sets cycle_cnt to 0, then → IDLE.
- Breakpoint hit: bp_en=1, mic1_en=1 this cycle, and cycle_cnt+1 == bp_value. The counter then holds bp_value in BREAK. Resuming runs past it, and it re-triggers only after wrap.
- If stop_p and a breakpoint hit occur in the same cycle, stop wins → IDLE. The cycle's increment still occurs.

## Timing
- Reset values:
  - State IDLE.
  - cycle_cnt=0, step_left=0.
  - mic1_en=0, mic1_clear=0, led_run=0, led_break=0, led_idle=1, led_step=0.
  - Debouncer sync flops, counters, stable level and edge register all 0, so no pulse is generated on reset release.
- Button latency: a clean level change on a raw button produces its pulse exactly DB_CYCLES+3 clk cycles after the first sampling edge. This is 2 synchronizer flops, DB_CYCLES stable count, and 1 edge register.
- Bounce shorter than DB_CYCLES restarts the stable count. No pulse is produced.
- Pulse → state → outputs: a pulse in cycle n puts the new state, and mic1_en/LEDs, in place at cycle n+1.
- A STEP burst is exactly STEP_LEN consecutive mic1_en cycles, then IDLE.
- Reset asserted mid-run forces mic1_en low asynchronously and clears all counters.

## Structure
- Package mic1_run_ctrl_pkg:
  - state enum (IDLE, RUN, STEP, BREAK, CLEAR), 3-bit encoding.
  - Default parameter constants.
- Sub-module btn_debounce, parameter DB_CYCLES, instantiated 4×:
  - 2-flop synchronizer.
  - Saturating stable counter of width $clog2(DB_CYCLES+1).
  - Stable level register.
  - Rise-pulse output.
- Top level holds the FSM, cycle_cnt, step_left and breakpoint compare.

## Test plan
All scenarios use DB_CYCLES=4, CNT_W=8, STEP_LEN=3.
- Reset, then press run for 20 cycles → pulse at +7 cycles. mic1_en high from next cycle, cycle_cnt counts 1,2,3…, led_run=1. Stop press → mic1_en drops one cycle after stop_p, count frozen.
- Step press held for 50 cycles in IDLE → exactly 3 mic1_en cycles, cycle_cnt +3, return to IDLE. Only one burst occurs.
- bp_en=1, bp_value=10, run → mic1_en low once cycle_cnt=10, led_break=1. Run again → count proceeds to 11, 12…
- Button bouncing with 3-cycle high glitches → no pulse and no state change. Followed by a stable press → single pulse.
- Clear pressed during RUN with cycle_cnt=37 → one-cycle mic1_clear=1, cycle_cnt=0, state IDLE.
- Reset asserted in mid-STEP burst → all outputs at reset values immediately. After release, no spurious pulse and IDLE is held.
